// File: rtl/demux_1_to_8_deser.sv
// Receive end of the 8-to-1 time-multiplexed link: slot counter, one-hot demux and word reassembly.
// Optional odd-parity slot after bit 7 is built when DEMUX_PARITY_EN is defined.
module demux_1_to_8_deser (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       sof,
  input  logic       din,
  output logic [2:0] sel,
  output logic [7:0] y,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
  output logic       err
);

  // state  | meaning
  // IDLE   | waiting for en&sof, nothing captured
  // SHIFT  | collecting word bits, idx = slot of next bit
  // PARITY | waiting for the odd-parity bit (parity builds only)
`ifdef DEMUX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t     state, state_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shreg, shreg_n;
  logic [7:0] y_n, data_n;
  logic       valid_n, err_n;
  logic       start;

  assign start = en & sof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start) state_n = SHIFT;
      SHIFT: begin
        if (start) state_n = SHIFT;
        else if (en && idx == 3'd7) begin
`ifdef DEMUX_PARITY_EN
          state_n = PARITY;
`else
          state_n = IDLE;
`endif
        end
      end
`ifdef DEMUX_PARITY_EN
      PARITY: begin
        if (start)   state_n = SHIFT;
        else if (en) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // A restart takes priority over completing the current word; its bit lands in slot 0.
  always_comb begin
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = data;
    y_n     = 8'd0;
    valid_n = 1'b0;
    err_n   = 1'b0;
    if (start) begin
      shreg_n = {7'd0, din};
      idx_n   = 3'd1;
      y_n     = {7'd0, din};
      err_n   = (state != IDLE);
    end else if (en) begin
      case (state)
        SHIFT: begin
          shreg_n[idx] = din;
          y_n          = {7'd0, din} << idx;
          if (idx == 3'd7) begin
            idx_n = 3'd0;
`ifndef DEMUX_PARITY_EN
            data_n  = shreg_n;
            valid_n = 1'b1;
`endif
          end else begin
            idx_n = idx + 3'd1;
          end
        end
`ifdef DEMUX_PARITY_EN
        PARITY: begin
          y_n   = {7'd0, din};
          idx_n = 3'd0;
          if (^{shreg, din}) begin
            data_n  = shreg;
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= 3'd0;
      shreg <= 8'd0;
      y     <= 8'd0;
      data  <= 8'd0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      idx   <= idx_n;
      shreg <= shreg_n;
      y     <= y_n;
      data  <= data_n;
      valid <= valid_n;
      err   <= err_n;
    end
  end

  assign sel  = (state == SHIFT) ? idx : 3'd0;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_demux_1_to_8_deser.sv
// Bench for demux_1_to_8_deser: directed frames plus random traffic against a bit-count frame model.
module tb_demux_1_to_8_deser;

`ifdef DEMUX_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n, en, sof, din;
  logic [2:0] sel;
  logic [7:0] y, data;
  logic       valid, busy, err;

  int n_cmp = 0;
  int n_bad = 0;

  bit         m_active;
  int         m_cnt;
  logic [7:0] m_word, e_data, e_y;
  logic       e_valid, e_err;

  demux_1_to_8_deser dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sof(sof), .din(din),
    .sel(sel), .y(y), .data(data), .valid(valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_cnt = 0; m_word = 8'd0;
    e_data = 8'd0; e_y = 8'd0; e_valid = 1'b0; e_err = 1'b0;
  endtask

  // Frame model: count accepted bits since sof; the word finishes on bit FRAME-1.
  task automatic model_step(input logic e, input logic s, input logic d);
    e_valid = 1'b0; e_err = 1'b0; e_y = 8'd0;
    if (e) begin
      if (s) begin
        e_err = m_active; m_active = 1; m_cnt = 1;
        m_word = {7'd0, d}; e_y = {7'd0, d};
      end else if (m_active) begin
        if (m_cnt < 8) begin
          m_word[m_cnt] = d;
          e_y = {7'd0, d} << m_cnt;
        end else begin
          e_y = {7'd0, d};
        end
        m_cnt++;
        if (m_cnt == FRAME) begin
          m_active = 0;
          if (FRAME == 8 || ($countones({m_word, d}) % 2 == 1)) begin
            e_data = m_word; e_valid = 1'b1;
          end else begin
            e_err = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [2:0] e_sel;
    e_sel = (m_active && m_cnt < 8) ? m_cnt[2:0] : 3'd0;
    chk("y", y, e_y);
    chk("data", data, e_data);
    chk("valid", valid, e_valid);
    chk("err", err, e_err);
    chk("busy", busy, m_active);
    chk("sel", sel, e_sel);
    chk("err_valid_excl", valid & err, 0);
  endtask

  task automatic step(input logic e, input logic s, input logic d);
    en = e; sof = s; din = d;
    @(posedge clk);
    model_step(e, s, d);
    #1;
    compare_all();
  endtask

  task automatic send_tail(input logic [7:0] w, input bit par_ok);
    for (int i = 1; i < 8; i++) step(1, 0, w[i]);
`ifdef DEMUX_PARITY_EN
    step(1, 0, par_ok ? ~^w : ^w);
`else
    if (!par_ok) $display("note: parity not built");
`endif
  endtask

  task automatic send_word(input logic [7:0] w, input bit par_ok);
    step(1, 1, w[0]);
    send_tail(w, par_ok);
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] onehot;
    rst_n = 1'b0; en = 1'b0; sof = 1'b0; din = 1'b0;
    model_reset();
    #12;
    compare_all();
    rst_n = 1'b1;

    // basic frame
    send_word(8'hA5, 1);
    chk("basic_data", data, 8'hA5);
    chk("basic_valid", valid, 1);
    step(1, 0, 0);
    chk("basic_valid_drop", valid, 0);
    chk("basic_busy_drop", busy, 0);

    // one-hot walk
    step(1, 1, 1);
    chk("walk_y0", y, 8'h01);
    for (int i = 1; i < 8; i++) begin
      step(1, 0, 1);
      onehot = 8'd1 << i;
      chk("walk_y", y, onehot);
    end
`ifdef DEMUX_PARITY_EN
    step(1, 0, 0);
`endif
    step(1, 0, 0);
    chk("walk_y_end", y, 8'h00);
    chk("walk_sel_end", sel, 0);

    // pause after slot 4
    w = 8'h3C;
    step(1, 1, w[0]);
    for (int i = 1; i < 5; i++) step(1, 0, w[i]);
    for (int i = 0; i < 3; i++) begin
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("pause_y", y, 8'h00);
      chk("pause_sel", sel, 5);
      chk("pause_busy", busy, 1);
    end
    for (int i = 5; i < 8; i++) step(1, 0, w[i]);
`ifdef DEMUX_PARITY_EN
    step(1, 0, ~^w);
`endif
    chk("pause_data", data, 8'h3C);

    // framing restart at slot 4
    w = 8'h5A;
    step(1, 1, w[0]);
    for (int i = 1; i < 4; i++) step(1, 0, w[i]);
    w = 8'h96;
    step(1, 1, w[0]);
    chk("restart_err", err, 1);
    send_tail(w, 1);
    chk("restart_data", data, 8'h96);

    // back-to-back frames
    send_word(8'h5A, 1);
    send_word(8'hC3, 1);
    chk("b2b_data", data, 8'hC3);

    // async reset mid-frame
    w = 8'h77;
    step(1, 1, w[0]);
    for (int i = 1; i < 5; i++) step(1, 0, w[i]);
    chk("mid_sel", sel, 5);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    #2 rst_n = 1'b1;
    send_word(8'hFF, 1);
    chk("after_reset_data", data, 8'hFF);

`ifdef DEMUX_PARITY_EN
    send_word(8'h01, 1);
    chk("par_ok_valid", valid, 1);
    chk("par_ok_data", data, 8'h01);
    send_word(8'h03, 0);
    chk("par_bad_err", err, 1);
    chk("par_bad_data", data, 8'h01);
`endif

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      logic e, s, d;
      e = ($urandom_range(0, 9) != 0);
      s = m_active ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 3) == 0);
      d = 1'($urandom_range(0, 1));
      step(e, s, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
